// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//
// Instruction fetch stage. Owns the PC, issues one request at a time to a
// variable-latency instruction memory, holds the returned word on
// instr/instr_valid until the datapath retires it, then moves the PC to the
// sequential, branch or jump successor.
//
// Handshakes (all sampled on the rising edge of clk):
//   request  : a request is accepted in a cycle where imem_req && imem_ready.
//              imem_req and imem_addr stay constant until acceptance.
//   response : imem_rvalid is only looked at while a request is outstanding
//              (S_WAIT); at most one request is ever outstanding.
//   retire   : retire is only looked at while instr_valid is high (S_HOLD);
//              branch_taken/jump are sampled together with it.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   imem_req/addr       fetch request and byte address (addr == pc)
//   imem_ready          memory accepts the request this cycle
//   imem_rvalid/rdata   returned instruction word
//   instr, instr_valid  held instruction for controller/datapath
//   retire              datapath consumed instr this cycle
//   branch_taken, jump  next-PC selection, valid with retire
//   pc, pc_plus4        current instruction address and pc + 4
//   state_dbg           current FSM state (S_REQ=0, S_WAIT=1, S_HOLD=2)
// ---------------------------------------------------------------------------
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        retire,
  input  logic        branch_taken,
  input  logic        jump,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  logic [31:0] branch_off;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] next_pc;

  // Successor address. Jump keeps the upper nibble of pc + 4; branch adds a
  // sign-extended word offset to pc + 4. Both are word aligned by construction.
  assign pc_plus4      = pc_q + 32'd4;
  assign branch_off    = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign branch_target = pc_plus4 + branch_off;
  assign jump_target   = {pc_plus4[31:28], instr_q[25:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_REQ: begin
        // A response arriving alongside acceptance belongs to nothing we
        // asked for, so only imem_ready matters here.
        if (imem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (retire) begin
          pc_d    = next_pc;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  assign imem_req    = (state_q == S_REQ);
  assign instr_valid = (state_q == S_HOLD);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign state_dbg   = state_q;

endmodule
